// File: rtl/flash_fetch_ctrl.sv
// Flash port sequencer: byte-wise 32-bit instruction fetch plus one arbitrated data requester.
// Optional write read-back verification is enabled by defining FLASH_WR_VERIFY_EN.
module flash_fetch_ctrl #(
   parameter int ADDR_W   = 24,
   parameter int READ_LAT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   output logic              instr_valid,
   output logic [31:0]       instr,
   input  logic [ADDR_W-1:0] pc_out,
   output logic [1:0]        pc_control,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [7:0]        d_wdata,
   output logic              d_ack,
   output logic [7:0]        d_rdata,
   output logic              d_err,
   output logic              flash_we,
   output logic              flash_re,
   output logic [ADDR_W-1:0] flash_addr,
   output logic [7:0]        flash_wdata,
   input  logic [7:0]        flash_rdata
);

   localparam int CW = $clog2(READ_LAT + 2);
   localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LAT - 1);
   localparam logic [CW-1:0] LAST_DRD  = CW'(READ_LAT);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] F_ADDR = 3'd1;
   localparam logic [2:0] F_WAIT = 3'd2;
   localparam logic [2:0] F_INC  = 3'd3;
   localparam logic [2:0] F_DONE = 3'd4;
   localparam logic [2:0] D_RD   = 3'd5;
   localparam logic [2:0] D_WR   = 3'd6;
   localparam logic [2:0] D_VFY  = 3'd7;

   logic [2:0]        state;
   logic [1:0]        k;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] f_addr;
   logic              d_ack_q;
`ifdef FLASH_WR_VERIFY_EN
   logic              d_err_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         k       <= '0;
         cnt     <= '0;
         f_addr  <= '0;
         instr   <= '0;
         d_rdata <= '0;
         d_ack_q <= 1'b0;
`ifdef FLASH_WR_VERIFY_EN
         d_err_q <= 1'b0;
`endif
      end else begin
         d_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               // a requester still holding d_req during its own ack cycle must not be re-granted
               if (d_req && !d_ack_q) begin
                  cnt   <= '0;
                  state <= d_we ? D_WR : D_RD;
               end else if (fetch_req) begin
                  k     <= '0;
                  state <= F_ADDR;
               end
            end
            F_ADDR: begin
               f_addr <= pc_out;
               cnt    <= '0;
               state  <= F_WAIT;
            end
            F_WAIT: begin
               if (cnt == LAST_WAIT) begin
                  instr[{k, 3'b000} +: 8] <= flash_rdata;
                  state <= F_INC;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            F_INC: begin
               if (k == 2'd3) begin
                  state <= F_DONE;
               end else begin
                  k     <= k + 1'b1;
                  state <= F_ADDR;
               end
            end
            F_DONE: state <= IDLE;
            D_RD: begin
               if (cnt == LAST_DRD) begin
                  d_rdata <= flash_rdata;
                  d_ack_q <= 1'b1;
`ifdef FLASH_WR_VERIFY_EN
                  d_err_q <= 1'b0;
`endif
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            D_WR: begin
`ifdef FLASH_WR_VERIFY_EN
               cnt   <= '0;
               state <= D_VFY;
`else
               d_ack_q <= 1'b1;
               state   <= IDLE;
`endif
            end
`ifdef FLASH_WR_VERIFY_EN
            D_VFY: begin
               if (cnt == LAST_DRD) begin
                  d_rdata <= flash_rdata;
                  d_err_q <= (flash_rdata != d_wdata);
                  d_ack_q <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      flash_re    = 1'b0;
      flash_we    = 1'b0;
      flash_addr  = '0;
      flash_wdata = '0;
      pc_control  = 2'b00;
      case (state)
         F_ADDR: begin
            flash_re   = 1'b1;
            flash_addr = pc_out;
         end
         F_WAIT: begin
            flash_re   = 1'b1;
            flash_addr = f_addr;
         end
         F_INC: begin
            pc_control = 2'b01;
            flash_addr = f_addr;
         end
         D_RD, D_VFY: begin
            flash_re   = 1'b1;
            flash_addr = d_addr;
         end
         D_WR: begin
            flash_we    = 1'b1;
            flash_addr  = d_addr;
            flash_wdata = d_wdata;
         end
         default: ;
      endcase
   end

   assign instr_valid = (state == F_DONE);
   assign d_ack       = d_ack_q;
`ifdef FLASH_WR_VERIFY_EN
   assign d_err = d_err_q;
`else
   assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Scoreboard bench for flash_fetch_ctrl with a byte-wide flash model and a program counter model.
// Honours FLASH_WR_VERIFY_EN for write cost and read-back expectations.
module tb_flash_fetch_ctrl;

   localparam int ADDR_W   = 24;
   localparam int READ_LAT = 3;
   localparam int LIMIT    = 200;
   localparam int FETCH_CYC = 4 * (READ_LAT + 2) + 1;
`ifdef FLASH_WR_VERIFY_EN
   localparam int WR_COST = READ_LAT + 3;
`else
   localparam int WR_COST = 2;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              fetch_req = 1'b0;
   logic              instr_valid;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] pc = '0;
   logic [1:0]        pc_control;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [7:0]        d_wdata = '0;
   logic              d_ack;
   logic [7:0]        d_rdata;
   logic              d_err;
   logic              flash_we;
   logic              flash_re;
   logic [ADDR_W-1:0] flash_addr;
   logic [7:0]        flash_wdata;
   logic [7:0]        flash_rdata;

   logic [7:0]        mem [0:255];
   logic [ADDR_W-1:0] pipe [0:READ_LAT-1];
   logic              mem_clr = 1'b1;
   logic              pl_en = 1'b0;
   logic [7:0]        pl_addr = '0;
   logic [7:0]        pl_data = '0;
   logic              pc_ld = 1'b0;
   logic [ADDR_W-1:0] pc_ld_val = '0;
   logic              force_zero = 1'b0;
   int                inc_cnt = 0;

   logic [31:0] q_instr [$];
   logic [8:0]  q_d [$];
   int checks = 0;
   int failures = 0;
   int viol = 0;
   logic prev_inc = 1'b0;

   always #5 clk = ~clk;

   flash_fetch_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .instr_valid(instr_valid),
      .instr(instr), .pc_out(pc), .pc_control(pc_control), .d_req(d_req),
      .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .d_rdata(d_rdata), .d_err(d_err), .flash_we(flash_we), .flash_re(flash_re),
      .flash_addr(flash_addr), .flash_wdata(flash_wdata), .flash_rdata(flash_rdata)
   );

   // flash returns mem[addr] READ_LAT cycles after the address is presented
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end
      if (flash_we) mem[flash_addr[7:0]] <= flash_wdata;
      for (int i = READ_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= flash_addr;
      if (pc_ld) begin
         pc <= pc_ld_val;
      end else if (pc_control == 2'b01) begin
         pc      <= pc + 1'b1;
         inc_cnt <= inc_cnt + 1;
      end
   end

   assign flash_rdata = force_zero ? 8'h00 : mem[pipe[READ_LAT-1][7:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (flash_we && flash_re) viol++;
         if (pc_control == 2'b01 && (flash_re || flash_we || prev_inc)) viol++;
         if (pc_control[1]) viol++;
         prev_inc = (pc_control == 2'b01);
         if (instr_valid) begin
            if (q_instr.size() == 0) check("instr_unexpected", 32'd1, 32'd0);
            else check("instr", instr, q_instr.pop_front());
         end
         if (d_ack) begin
            if (q_d.size() == 0) begin
               check("d_ack_unexpected", 32'd1, 32'd0);
            end else begin
               logic [8:0] e;
               e = q_d.pop_front();
               check("d_rdata", {24'd0, d_rdata}, {24'd0, e[8:1]});
               check("d_err", {31'd0, d_err}, {31'd0, e[0]});
            end
         end
      end else begin
         prev_inc = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_addr = a[7:0];
      pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic load_pc(input int a);
      pc_ld = 1'b1;
      pc_ld_val = ADDR_W'(a);
      tick();
      pc_ld = 1'b0;
   endtask

   task automatic wait_instr(output int n);
      n = -1;
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         if (instr_valid) begin
            n = i;
            break;
         end
      end
      if (n < 0) check("instr_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_ack(output int n);
      n = -1;
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         if (d_ack) begin
            n = i;
            break;
         end
      end
      if (n < 0) check("d_ack_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      int inc0;
      repeat (3) tick();
      check("rst_instr", instr, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_d_ack", {31'd0, d_ack}, 32'd0);
      check("rst_d_rdata", {24'd0, d_rdata}, 32'd0);
      check("rst_d_err", {31'd0, d_err}, 32'd0);
      check("rst_flash_en", {30'd0, flash_we, flash_re}, 32'd0);
      check("rst_pc_control", {30'd0, pc_control}, 32'd0);
      check("rst_flash_addr", {8'd0, flash_addr}, 32'd0);
      reset = 1'b0;
      mem_clr = 1'b0;

      // single fetch from pc=0
      preload(0, 8'h83); preload(1, 8'h02); preload(2, 8'h10); preload(3, 8'h00);
      load_pc(0);
      inc0 = inc_cnt;
      q_instr.push_back(32'h0010_0283);
      fetch_req = 1'b1;
      wait_instr(n);
      fetch_req = 1'b0;
      check("fetch_latency", n, FETCH_CYC);
      tick();
      check("pc_after_fetch1", {8'd0, pc}, 32'd4);
      check("pc_pulses_fetch1", inc_cnt - inc0, 32'd4);

      // back-to-back fetches from pc=4
      preload(4, 8'h03); preload(5, 8'h03); preload(6, 8'h20); preload(7, 8'h00);
      preload(8, 8'hb3); preload(9, 8'h83); preload(10, 8'h62); preload(11, 8'h00);
      q_instr.push_back(32'h0020_0303);
      q_instr.push_back(32'h0062_83b3);
      fetch_req = 1'b1;
      wait_instr(n);
      wait_instr(n);
      fetch_req = 1'b0;
      check("b2b_latency", n, FETCH_CYC + 1);
      tick();
      check("pc_after_b2b", {8'd0, pc}, 32'd12);

      // data read
      preload(32'h20, 8'h10);
      q_d.push_back({8'h10, 1'b0});
      d_req = 1'b1; d_we = 1'b0; d_addr = 24'h20;
      wait_ack(n);
      d_req = 1'b0;
      check("rd_latency", n, READ_LAT + 2);
      tick();
      check("pc_after_rd", {8'd0, pc}, 32'd12);

      // simultaneous write and fetch: write first
      preload(12, 8'h13); preload(13, 8'h05); preload(14, 8'h10); preload(15, 8'h00);
`ifdef FLASH_WR_VERIFY_EN
      q_d.push_back({8'h14, 1'b0});
`else
      q_d.push_back({8'h10, 1'b0});
`endif
      q_instr.push_back(32'h0010_0513);
      d_req = 1'b1; d_we = 1'b1; d_addr = 24'h21; d_wdata = 8'h14;
      fetch_req = 1'b1;
      wait_ack(n);
      d_req = 1'b0;
      check("wr_latency", n, WR_COST);
      check("fetch_pending_at_wr_ack", q_instr.size(), 32'd1);
      wait_instr(n);
      fetch_req = 1'b0;
      tick();
      check("flash_wr_byte", {24'd0, mem[8'h21]}, 32'h14);
      check("pc_after_wr_fetch", {8'd0, pc}, 32'd16);
`ifdef FLASH_WR_VERIFY_EN
      q_d.push_back({8'h00, 1'b1});
      force_zero = 1'b1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 24'h22; d_wdata = 8'h55;
      wait_ack(n);
      d_req = 1'b0;
      force_zero = 1'b0;
      check("vfy_latency", n, WR_COST);
      tick();
`endif

      // reset during F_WAIT of byte 2
      preload(16, 8'hef); preload(17, 8'hbe); preload(18, 8'had); preload(19, 8'hde);
      load_pc(16);
      fetch_req = 1'b1;
      repeat (13) tick();
      check("pre_reset_re", {31'd0, flash_re}, 32'd1);
      reset = 1'b1;
      fetch_req = 1'b0;
      tick();
      check("mid_rst_flash_re", {31'd0, flash_re}, 32'd0);
      check("mid_rst_instr", instr, 32'd0);
      check("mid_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      reset = 1'b0;
      repeat (30) tick();
      check("pc_after_abort", {8'd0, pc}, 32'd18);
      load_pc(16);
      q_instr.push_back(32'hdead_beef);
      fetch_req = 1'b1;
      wait_instr(n);
      fetch_req = 1'b0;
      check("restart_latency", n, FETCH_CYC);
      tick();
      check("pc_after_restart", {8'd0, pc}, 32'd20);

      repeat (5) tick();
      check("instr_queue_empty", q_instr.size(), 32'd0);
      check("data_queue_empty", q_d.size(), 32'd0);
      check("invariant_violations", viol, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
